stream_mux_rr: RTL

//  Parametrised N-channel, WIDTH-bit multiplexer with valid/ready handshake on every input
//   and on the output, plus a registered output stage.
//  Two selection modes:
//   - MANUAL: an external select picks the channel.
//   - ROUND-ROBIN: an internal fair arbiter picks among the valid channels.

---
 rtl/mux_pkg.sv | 13 +
 rtl/rr_arbiter.sv | 32 +++
 rtl/stream_mux_rr.sv | 100 ++++++++++
 3 files changed

// File: rtl/mux_pkg.sv
// Shared definitions for the stream multiplexer: mode encodings
// and the wrapped channel-index increment used by the round-robin pointer.
package mux_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_RR     = 1'b1;

    // Next channel index after idx, wrapping to 0 past n-1.
    function automatic int inc_wrap(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Rotate-priority search: the first valid channel at or after ptr wins.
// Ports: in_valid (per channel), ptr (start index) -> grant_valid, grant_idx.
module rr_arbiter #(
    parameter int NUM_CH = 4,
    parameter int SEL_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] in_valid,
    input  logic [SEL_W-1:0]  ptr,
    output logic              grant_valid,
    output logic [SEL_W-1:0]  grant_idx
);
    import mux_pkg::*;

    int idx;

    // Scan from the farthest offset down so the nearest valid
    // channel to ptr is the one left in the outputs.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (in_valid[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = SEL_W'(idx);
            end
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream mux with manual or round-robin select
// and a single-entry registered output (in_* -> out_data/out_ch/out_valid).
module stream_mux_rr #(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 4,
    parameter int SEL_W  = $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    input  logic [NUM_CH-1:0]       in_valid,
    output logic [NUM_CH-1:0]       in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_ch,
    output logic                    out_valid,
    input  logic                    out_ready
);
    import mux_pkg::*;

    logic [SEL_W-1:0] ptr;
    logic             rr_valid;
    logic [SEL_W-1:0] rr_idx;
    logic             man_valid;
    logic             grant_valid;
    logic [SEL_W-1:0] grant_idx;
    logic [WIDTH-1:0] grant_data;
    logic             can_load;
    logic             load;

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .SEL_W  (SEL_W)
    ) u_arb (
        .in_valid    (in_valid),
        .ptr         (ptr),
        .grant_valid (rr_valid),
        .grant_idx   (rr_idx)
    );

    // Matching sel against every legal index means an
    // out-of-range sel simply never matches.
    always_comb begin
        man_valid = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (sel == SEL_W'(i) && in_valid[i]) man_valid = 1'b1;
        end
    end

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        if (mode == MODE_RR) begin
            grant_valid = rr_valid;
            grant_idx   = rr_idx;
        end else begin
            grant_valid = man_valid;
            grant_idx   = sel;
        end
    end

    always_comb begin
        grant_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant_idx == SEL_W'(i)) grant_data = in_data[i*WIDTH +: WIDTH];
        end
    end

    assign can_load = !out_valid || out_ready;
    assign load     = !rst && can_load && grant_valid;

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (load && grant_idx == SEL_W'(i)) in_ready[i] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr       <= '0;
        end else begin
            if (load) begin
                out_valid <= 1'b1;
                out_data  <= grant_data;
                out_ch    <= grant_idx;
                if (mode == MODE_RR) begin
                    ptr <= SEL_W'(inc_wrap(int'(grant_idx), NUM_CH));
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
